tx_ethernet: RTL and testbench

GMII Ethernet II frame transmitter. It is the transmit-side counterpart of the rx_ethernet receiver in the Vthernet MAC.
- On a start pulse it emits preamble, SFD, destination MAC, source MAC and length/type.
- It then streams the payload from TX buffer memory, zero-pads if configured, and appends CRC-32 FCS.
- It ends with a mandatory inter-frame gap.
- It sits between the Wishbone CSR block (frame descriptor, start) and the GMII TX pins.

---
 rtl/tx_ethernet.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_tx_ethernet.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ethernet.sv
// GMII Ethernet II frame transmitter: preamble/SFD, MAC header, payload from TX memory, FCS, IFG.
// Optional zero padding to the 46-byte minimum payload is enabled by defining TX_PAD_EN.
module tx_ethernet #(
   parameter int unsigned    OCT         = 8,
   parameter logic [OCT-1:0] PRE         = 8'b10101010,
   parameter logic [OCT-1:0] SFD         = 8'b10101011,
   parameter int unsigned    PRE_BYTES   = 7,
   parameter int unsigned    IFG_BYTES   = 12,
   parameter int unsigned    MAX_PAYLOAD = 1500
) (
   input  logic           TX_CLK,
   input  logic           rst_n,
   input  logic           tx_start,
   input  logic           tx_abort,
   input  logic [47:0]    tx_dst_mac,
   input  logic [47:0]    mac_addr,
   input  logic [15:0]    tx_len_type,
   input  logic [10:0]    tx_payload_len,
   output logic [10:0]    tx_addr,
   output logic           tx_mem_re,
   input  logic [OCT-1:0] tx_mem_out,
   output logic           TX_EN,
   output logic [OCT-1:0] TXD,
   output logic           TX_ER,
   output logic           tx_busy,
   output logic           tx_irq
);

   localparam int unsigned LW        = 11;
   localparam int unsigned MAC_BYTES = 6;
   localparam int unsigned FCS_BYTES = 4;
`ifdef TX_PAD_EN
   localparam int unsigned MIN_PAYLOAD = 46;
`endif

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_PRE   = 4'd1;
   localparam logic [3:0] ST_SFD   = 4'd2;
   localparam logic [3:0] ST_DST   = 4'd3;
   localparam logic [3:0] ST_SRC   = 4'd4;
   localparam logic [3:0] ST_TYPE  = 4'd5;
   localparam logic [3:0] ST_DATA  = 4'd6;
`ifdef TX_PAD_EN
   localparam logic [3:0] ST_PAD   = 4'd7;
`endif
   localparam logic [3:0] ST_FCS   = 4'd8;
   localparam logic [3:0] ST_ABORT = 4'd9;
   localparam logic [3:0] ST_IFG   = 4'd10;

   // state_q names the byte currently on TXD; cnt_q is its index within that field
   logic [3:0]     state_q, state_d;
   logic [LW-1:0]  cnt_q, cnt_d;
   logic [OCT-1:0] txd_q, txd_d;
   logic           en_q, en_d, er_q, er_d;
   logic           re_q, re_d;
   logic [LW-1:0]  addr_q, addr_d;
   logic           busy_q, busy_d, irq_q, irq_d;
   logic [31:0]    crc_q, crc_d, fcs_q, fcs_d;
   logic [47:0]    dst_q, dst_d, src_q, src_d;
   logic [15:0]    type_q, type_d;
   logic [LW-1:0]  len_q, len_d;
   logic           crc_upd, tail, fcs_go;

   // Reflected CRC-32 update, one byte LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [OCT-1:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < int'(OCT); i++)
         c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      txd_d   = '0;
      re_d    = 1'b0;
      addr_d  = addr_q;
      busy_d  = busy_q;
      irq_d   = 1'b0;
      crc_d   = crc_q;
      fcs_d   = fcs_q;
      dst_d   = dst_q;
      src_d   = src_q;
      type_d  = type_q;
      len_d   = len_q;
      crc_upd = 1'b0;
      tail    = 1'b0;
      fcs_go  = 1'b0;

      if (en_q && tx_abort && (state_q != ST_ABORT)) begin
         state_d = ST_ABORT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tx_start) begin
                  state_d = ST_PRE;
                  cnt_d   = '0;
                  txd_d   = PRE;
                  busy_d  = 1'b1;
                  crc_d   = '1;
                  dst_d   = tx_dst_mac;
                  src_d   = mac_addr;
                  type_d  = tx_len_type;
                  len_d   = (tx_payload_len > LW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : tx_payload_len;
               end
            end
            ST_PRE: begin
               if (cnt_q == LW'(PRE_BYTES - 1)) begin
                  state_d = ST_SFD;
                  txd_d   = SFD;
               end else begin
                  cnt_d = cnt_q + LW'(1);
                  txd_d = PRE;
               end
            end
            ST_SFD: begin
               state_d = ST_DST;
               cnt_d   = '0;
               txd_d   = dst_q[47:40];
               dst_d   = dst_q << 8;
               crc_upd = 1'b1;
            end
            ST_DST: begin
               crc_upd = 1'b1;
               if (cnt_q == LW'(MAC_BYTES - 1)) begin
                  state_d = ST_SRC;
                  cnt_d   = '0;
                  txd_d   = src_q[47:40];
                  src_d   = src_q << 8;
               end else begin
                  cnt_d = cnt_q + LW'(1);
                  txd_d = dst_q[47:40];
                  dst_d = dst_q << 8;
               end
            end
            ST_SRC: begin
               crc_upd = 1'b1;
               if (cnt_q == LW'(MAC_BYTES - 1)) begin
                  state_d = ST_TYPE;
                  cnt_d   = '0;
                  txd_d   = type_q[15:8];
                  type_d  = type_q << 8;
                  // First memory read goes out two bytes ahead of payload byte 0
                  if (len_q != '0) begin
                     re_d   = 1'b1;
                     addr_d = '0;
                  end
               end else begin
                  cnt_d = cnt_q + LW'(1);
                  txd_d = src_q[47:40];
                  src_d = src_q << 8;
               end
            end
            ST_TYPE: begin
               if (cnt_q == '0) begin
                  cnt_d   = LW'(1);
                  txd_d   = type_q[15:8];
                  crc_upd = 1'b1;
               end else if (len_q != '0) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  txd_d   = tx_mem_out;
                  crc_upd = 1'b1;
               end else begin
                  tail = 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_q == len_q - LW'(1)) begin
                  tail = 1'b1;
               end else begin
                  cnt_d   = cnt_q + LW'(1);
                  txd_d   = tx_mem_out;
                  crc_upd = 1'b1;
               end
            end
`ifdef TX_PAD_EN
            ST_PAD: begin
               crc_upd = 1'b1;
               if (cnt_q == LW'(MIN_PAYLOAD - 1)) fcs_go = 1'b1;
               else cnt_d = cnt_q + LW'(1);
            end
`endif
            ST_FCS: begin
               if (cnt_q == LW'(FCS_BYTES - 1)) begin
                  state_d = ST_IFG;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + LW'(1);
                  txd_d   = fcs_q[7:0];
                  fcs_d   = fcs_q >> 8;
                  crc_upd = 1'b1;
               end
            end
            ST_ABORT: begin
               state_d = ST_IFG;
               cnt_d   = '0;
            end
            ST_IFG: begin
               // The IDLE/irq cycle is the last gap cycle, so a start there keeps the gap exact
               if (cnt_q == LW'(IFG_BYTES - 2)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  irq_d   = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + LW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase

         if (tail) begin
`ifdef TX_PAD_EN
            if (len_q < LW'(MIN_PAYLOAD)) begin
               state_d = ST_PAD;
               cnt_d   = len_q;
               crc_upd = 1'b1;
            end else begin
               fcs_go = 1'b1;
            end
`else
            fcs_go = 1'b1;
`endif
         end

         if (fcs_go) begin
            state_d = ST_FCS;
            cnt_d   = '0;
            txd_d   = ~crc_q[7:0];
            fcs_d   = {8'h00, ~crc_q[31:8]};
            crc_upd = 1'b1;
         end

         if (re_q && ((12'(addr_q) + 12'd1) < 12'(len_q))) begin
            re_d   = 1'b1;
            addr_d = addr_q + LW'(1);
         end
      end

      if (crc_upd) crc_d = crc_byte(crc_q, txd_d);
      en_d = (state_d != ST_IDLE) && (state_d != ST_IFG);
      er_d = (state_d == ST_ABORT);
   end

   always_ff @(posedge TX_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         txd_q   <= '0;
         en_q    <= 1'b0;
         er_q    <= 1'b0;
         re_q    <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         irq_q   <= 1'b0;
         crc_q   <= '1;
         fcs_q   <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         type_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         en_q    <= en_d;
         er_q    <= er_d;
         re_q    <= re_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         irq_q   <= irq_d;
         crc_q   <= crc_d;
         fcs_q   <= fcs_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         type_q  <= type_d;
         len_q   <= len_d;
      end
   end

   assign TXD       = txd_q;
   assign TX_EN     = en_q;
   assign TX_ER     = er_q;
   assign tx_mem_re = re_q;
   assign tx_addr   = addr_q;
   assign tx_busy   = busy_q;
   assign tx_irq    = irq_q;

endmodule

// File: tb/tb_tx_ethernet.sv
// Scoreboard bench for tx_ethernet: expected wire bytes and memory addresses are queued at
// frame request and checked as the transmitter produces them.
module tb_tx_ethernet;

   localparam logic [7:0] PRE_B = 8'hAA;
   localparam logic [7:0] SFD_B = 8'hAB;
   localparam int         MAXP  = 1500;

   logic        TX_CLK = 1'b0;
   logic        rst_n;
   logic        tx_start, tx_abort;
   logic [47:0] tx_dst_mac, mac_addr;
   logic [15:0] tx_len_type;
   logic [10:0] tx_payload_len;
   logic [10:0] tx_addr;
   logic        tx_mem_re;
   logic [7:0]  tx_mem_out;
   logic        TX_EN, TX_ER, tx_busy, tx_irq;
   logic [7:0]  TXD;

   tx_ethernet dut (
      .TX_CLK(TX_CLK), .rst_n(rst_n), .tx_start(tx_start), .tx_abort(tx_abort),
      .tx_dst_mac(tx_dst_mac), .mac_addr(mac_addr), .tx_len_type(tx_len_type),
      .tx_payload_len(tx_payload_len), .tx_addr(tx_addr), .tx_mem_re(tx_mem_re),
      .tx_mem_out(tx_mem_out), .TX_EN(TX_EN), .TXD(TXD), .TX_ER(TX_ER),
      .tx_busy(tx_busy), .tx_irq(tx_irq)
   );

   always #5 TX_CLK = ~TX_CLK;

   // Registered memory; garbage when not read so a mistimed read shows up on the wire
   logic [7:0] mem [0:2047];
   always @(posedge TX_CLK) tx_mem_out <= tx_mem_re ? mem[tx_addr] : 8'hEE;

   int          vectors = 0, miscompares = 0;
   logic [8:0]  exp_q[$];
   logic [10:0] exp_addr_q[$];
   logic [7:0]  cap_q[$];
   int          en_cnt = 0, re_cnt = 0, zero_run = 0, gap = 0;
   logic        prev_en = 1'b0;
   logic [8:0]  mon_e;
   logic [10:0] mon_a;

   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   always @(negedge TX_CLK) begin
      if (TX_EN === 1'b1) begin
         cap_q.push_back(TXD);
         en_cnt++;
         if (!prev_en) gap = zero_run;
         zero_run = 0;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_byte: er=%b txd=%h, no byte required", TX_ER, TXD);
         end else begin
            mon_e = exp_q.pop_front();
            if ({TX_ER, TXD} !== mon_e) begin
               miscompares++;
               $display("FAIL wire_byte: got er=%b txd=%h, required er=%b txd=%h",
                        TX_ER, TXD, mon_e[8], mon_e[7:0]);
            end
         end
      end else begin
         zero_run++;
      end
      prev_en = TX_EN;
      if (tx_mem_re === 1'b1) begin
         re_cnt++;
         vectors++;
         if (exp_addr_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_read: addr=%0d, no read required", tx_addr);
         end else begin
            mon_a = exp_addr_q.pop_front();
            if (tx_addr !== mon_a) begin
               miscompares++;
               $display("FAIL read_addr: got %0d, required %0d", tx_addr, mon_a);
            end
         end
      end
   end

   task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] ty,
                             input int len, input int abort_at, output int exp_len);
      logic [31:0] crc;
      logic [47:0] d, s;
      logic [15:0] t;
      logic [7:0]  b;
      int plen, npad;
      plen = (len > MAXP) ? MAXP : len;
      npad = 0;
`ifdef TX_PAD_EN
      if (plen < 46) npad = 46 - plen;
`endif
      crc = 32'hFFFF_FFFF;
      d = dst; s = src; t = ty;
      for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, PRE_B});
      exp_q.push_back({1'b0, SFD_B});
      for (int i = 0; i < 6; i++) begin b = d[47:40]; d = d << 8; exp_q.push_back({1'b0, b}); crc = crc_step(crc, b); end
      for (int i = 0; i < 6; i++) begin b = s[47:40]; s = s << 8; exp_q.push_back({1'b0, b}); crc = crc_step(crc, b); end
      for (int i = 0; i < 2; i++) begin b = t[15:8]; t = t << 8; exp_q.push_back({1'b0, b}); crc = crc_step(crc, b); end
      if (abort_at >= 0) begin
         for (int k = 0; k <= abort_at; k++) exp_q.push_back({1'b0, mem[k]});
         exp_q.push_back(9'h100);
         for (int k = 0; k <= abort_at + 2 && k < plen; k++) exp_addr_q.push_back(11'(k));
         exp_len = 24 + abort_at;
      end else begin
         for (int k = 0; k < plen; k++) begin
            b = mem[k];
            exp_q.push_back({1'b0, b});
            crc = crc_step(crc, b);
            exp_addr_q.push_back(11'(k));
         end
         for (int k = 0; k < npad; k++) begin exp_q.push_back(9'h000); crc = crc_step(crc, 8'h00); end
         crc = ~crc;
         for (int i = 0; i < 4; i++) begin exp_q.push_back({1'b0, crc[7:0]}); crc = crc >> 8; end
         exp_len = 26 + plen + npad;
      end
   endtask

   // Called just after a falling edge; returns one falling edge after the start pulse
   task automatic start_frame(input logic [47:0] dst, input logic [15:0] ty, input int len,
                              input int abort_at, output int exp_len);
      tx_dst_mac     = dst;
      tx_len_type    = ty;
      tx_payload_len = 11'(len);
      push_frame(dst, mac_addr, ty, len, abort_at, exp_len);
      en_cnt = 0;
      re_cnt = 0;
      cap_q.delete();
      tx_start = 1'b1;
      @(negedge TX_CLK);
      tx_start = 1'b0;
      vectors++;
      if (tx_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_after_start: tx_busy=%b, required 1", tx_busy);
      end
      if (abort_at >= 0) begin
         repeat (22 + abort_at) @(negedge TX_CLK);
         tx_abort = 1'b1;
         @(negedge TX_CLK);
         tx_abort = 1'b0;
      end
   endtask

   // Returns on the falling edge of the tx_irq cycle
   task automatic wait_done(input string name, input int exp_len, input bit chk_res);
      int n;
      bit seen;
      logic [31:0] crc;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 4000) begin
         @(negedge TX_CLK);
         n++;
         if (tx_irq === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_irq_timeout: no tx_irq within %0d cycles", name, n);
      end else begin
         vectors++;
         if (en_cnt != exp_len) begin
            miscompares++;
            $display("FAIL %s_tx_en_len: got %0d cycles, required %0d", name, en_cnt, exp_len);
         end
         vectors++;
         if (tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_at_irq: tx_busy=%b, required 0", name, tx_busy);
         end
         vectors++;
         if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing: %0d bytes and %0d reads outstanding, required 0",
                     name, exp_q.size(), exp_addr_q.size());
         end
         if (chk_res) begin
            crc = 32'hFFFF_FFFF;
            for (int i = 8; i < cap_q.size(); i++) crc = crc_step(crc, cap_q[i]);
            vectors++;
            if (crc !== 32'hDEBB_20E3) begin
               miscompares++;
               $display("FAIL %s_residue: got %h, required debb20e3", name, crc);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      vectors++;
      if ({TX_EN, TXD, TX_ER, tx_busy, tx_irq, tx_mem_re, tx_addr} !== 30'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got en=%b txd=%h er=%b busy=%b irq=%b re=%b addr=%0d, required all 0",
                  TX_EN, TXD, TX_ER, tx_busy, tx_irq, tx_mem_re, tx_addr);
      end
      @(negedge TX_CLK);
      rst_n = 1'b1;
      en_cnt = 0;
      repeat (100) @(negedge TX_CLK);
      vectors++;
      if (en_cnt != 0) begin
         miscompares++;
         $display("FAIL idle_tx_en: got %0d enabled cycles, required 0", en_cnt);
      end
   endtask

   task automatic test_len64();
      int el;
      start_frame(48'h02_00_00_00_00_01, 16'h0800, 64, -1, el);
      wait_done("len64", el, 1'b1);
      vectors++;
      if (el != 90) begin
         miscompares++;
         $display("FAIL len64_expected_len: got %0d, required 90", el);
      end
      @(negedge TX_CLK);
      vectors++;
      if (tx_irq !== 1'b0) begin
         miscompares++;
         $display("FAIL irq_one_cycle: tx_irq=%b, required 0", tx_irq);
      end
   endtask

   task automatic test_len10();
      int el;
      start_frame(48'h02_00_00_00_00_01, 16'h0800, 10, -1, el);
      wait_done("len10", el, 1'b1);
   endtask

   task automatic test_len0();
      int el;
      @(negedge TX_CLK);
      start_frame(48'hFF_FF_FF_FF_FF_FF, 16'h88B5, 0, -1, el);
      wait_done("len0", el, 1'b1);
      vectors++;
      if (re_cnt != 0) begin
         miscompares++;
         $display("FAIL len0_reads: got %0d reads, required 0", re_cnt);
      end
   endtask

   task automatic test_busy_ignore();
      int el;
      @(negedge TX_CLK);
      start_frame(48'h0A_1B_2C_3D_4E_5F, 16'h0014, 20, -1, el);
      repeat (8) @(negedge TX_CLK);
      tx_dst_mac     = 48'h11_11_11_11_11_11;
      tx_payload_len = 11'd3;
      tx_start       = 1'b1;
      @(negedge TX_CLK);
      tx_start = 1'b0;
      wait_done("busy_ignore", el, 1'b1);
      en_cnt = 0;
      repeat (40) @(negedge TX_CLK);
      vectors++;
      if (en_cnt != 0) begin
         miscompares++;
         $display("FAIL busy_ignore_extra: got %0d enabled cycles after irq, required 0", en_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int el;
      @(negedge TX_CLK);
      start_frame(48'h02_00_00_00_00_0A, 16'h0800, 12, -1, el);
      wait_done("b2b_a", el, 1'b1);
      start_frame(48'h02_00_00_00_00_0B, 16'h86DD, 50, -1, el);
      wait_done("b2b_b", el, 1'b1);
      vectors++;
      if (gap != 12) begin
         miscompares++;
         $display("FAIL b2b_gap: got %0d idle cycles, required 12", gap);
      end
   endtask

   task automatic test_abort();
      int el;
      @(negedge TX_CLK);
      start_frame(48'h02_00_00_00_00_01, 16'h0800, 64, 5, el);
      wait_done("abort", el, 1'b0);
      start_frame(48'h02_00_00_00_00_03, 16'h0806, 30, -1, el);
      wait_done("after_abort", el, 1'b1);
   endtask

   task automatic test_reset_mid();
      int el;
      @(negedge TX_CLK);
      start_frame(48'h02_00_00_00_00_01, 16'h0800, 64, -1, el);
      repeat (32) @(negedge TX_CLK);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (TX_EN !== 1'b0 || tx_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got en=%b busy=%b before next edge, required 0 0", TX_EN, tx_busy);
      end
      exp_q.delete();
      exp_addr_q.delete();
      @(negedge TX_CLK);
      rst_n = 1'b1;
      @(negedge TX_CLK);
      start_frame(48'h02_00_00_00_00_04, 16'h0800, 16, -1, el);
      wait_done("after_reset", el, 1'b1);
   endtask

   task automatic test_clamp();
      int el;
      @(negedge TX_CLK);
      start_frame(48'h02_00_00_00_00_05, 16'h0800, 2000, -1, el);
      wait_done("clamp", el, 1'b1);
      vectors++;
      if (re_cnt != 1500) begin
         miscompares++;
         $display("FAIL clamp_reads: got %0d reads, required 1500", re_cnt);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      tx_start       = 1'b0;
      tx_abort       = 1'b0;
      tx_dst_mac     = '0;
      mac_addr       = 48'h02_00_00_00_00_02;
      tx_len_type    = '0;
      tx_payload_len = '0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i ^ (i >> 8));
      test_reset();
      test_len64();
      test_len10();
      test_len0();
      test_busy_ignore();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_clamp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
